// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The all-ones quotient for divide-by-zero. Users slice the low W bits, so W may not exceed 64.
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] DIVZERO_QUOT = '1;

endpackage

// File: rtl/div_step_restoring.sv
// One restoring-division iteration: shift in the next dividend bit, then trial-subtract the divisor.
module div_step_restoring #(
  parameter int W = 24
) (
  input  logic [W:0]   p,
  input  logic         msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   p_next,
  output logic         qbit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // The partial remainder stays below the divisor, so only the sign bit of diff matters.
  always_comb begin
    shifted = {p, msb};
    diff    = shifted - {2'b00, divisor};
    qbit    = ~diff[W+1];
    p_next  = qbit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/divider_seq_radix2.sv
// Sequential radix-2 restoring unsigned divider with a start/ready/done handshake.
// Optional feature macro: DIV_STICKY_EN adds sticky_o (= |Rem_o) for round/sticky logic.
module divider_seq_radix2
  import div_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] Data_A_i,
  input  logic [W-1:0] Data_B_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [W-1:0] Quot_o,
  output logic [W-1:0] Rem_o,
  output logic         div_zero_o
`ifdef DIV_STICKY_EN
  ,
  output logic         sticky_o
`else
  // sticky_o is absent; round logic derives sticky from Rem_o itself.
`endif
);

  localparam int CNT_W = $clog2(W + 1);

  // Handshake: a start is accepted on any edge where start_i & ready_o.
  // ready_o is high in IDLE and DONE. done_o pulses for one cycle at the edge
  // that loads Quot_o/Rem_o, which is the edge leaving DONE.
  state_t           state;
  state_t           state_next;
  logic [W:0]       p;
  logic [W:0]       p_step;
  logic             qbit;
  logic [W-1:0]     dividend;
  logic [W-1:0]     divisor;
  logic [CNT_W-1:0] count;
  logic             dz;
  logic             accept;

  assign accept = start_i & ready_o;

  div_step_restoring #(.W(W)) u_step (
    .p       (p),
    .msb     (dividend[W-1]),
    .divisor (divisor),
    .p_next  (p_step),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start_i)    state_next = (Data_B_i == '0) ? DONE : BUSY;
        else            state_next = IDLE;
      end
      BUSY: begin
        if (count == CNT_W'(1)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE) || (state == DONE);
  end

  // Iteration datapath and result registers; a start in DONE reloads the
  // operands on the same edge that publishes the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      p          <= '0;
      dividend   <= '0;
      divisor    <= '0;
      count      <= '0;
      dz         <= 1'b0;
      done_o     <= 1'b0;
      Quot_o     <= '0;
      Rem_o      <= '0;
      div_zero_o <= 1'b0;
    end else begin
      done_o <= (state == DONE);
      if (state == DONE) begin
        Quot_o     <= dz ? DIVZERO_QUOT[W-1:0] : dividend;
        Rem_o      <= dz ? dividend : p[W-1:0];
        div_zero_o <= dz;
      end
      if (accept) begin
        dividend <= Data_A_i;
        divisor  <= Data_B_i;
        p        <= '0;
        count    <= CNT_W'(W);
        dz       <= (Data_B_i == '0);
      end else if (state == BUSY) begin
        p        <= p_step;
        dividend <= {dividend[W-2:0], qbit};
        count    <= count - CNT_W'(1);
      end
    end
  end

`ifdef DIV_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst)                sticky_o <= 1'b0;
    else if (state == DONE) sticky_o <= dz ? (|dividend) : (|p[W-1:0]);
  end
`else
  // No sticky register in this build.
`endif

endmodule
